// File: rtl/fft_1d_8_in_buf_pkg.sv
// Shared sizes and packing helper for the 8-point FFT input buffer.
// Frames are flat buses with sample k in bits [k*DATA_W +: DATA_W].
package fft_1d_8_in_buf_pkg;

  localparam int FFT_DATA_W = 16;
  localparam int FFT_N_PT   = 8;
  localparam int FFT_IDX_W  = 3;

  typedef logic [FFT_DATA_W-1:0] sample_t;

  function automatic int slot_lo(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/fft_1d_8_in_bank.sv
// One frame of re/im sample storage with an indexed write port and a flat read.
// Contents are deliberately not reset; the full flags in the parent qualify them.
module fft_1d_8_in_bank
  import fft_1d_8_in_buf_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N_PT   = FFT_N_PT,
  parameter int IDX_W  = FFT_IDX_W
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [IDX_W-1:0]       idx,
  input  logic [DATA_W-1:0]      wr_re,
  input  logic [DATA_W-1:0]      wr_im,
  output logic [N_PT*DATA_W-1:0] rd_re,
  output logic [N_PT*DATA_W-1:0] rd_im
);

  logic [DATA_W-1:0] mem_re [N_PT];
  logic [DATA_W-1:0] mem_im [N_PT];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_re[idx] <= wr_re;
      mem_im[idx] <= wr_im;
    end
  end

  for (genvar k = 0; k < N_PT; k++) begin : g_read
    assign rd_re[slot_lo(k, DATA_W) +: DATA_W] = mem_re[k];
    assign rd_im[slot_lo(k, DATA_W) +: DATA_W] = mem_im[k];
  end

endmodule

// File: rtl/fft_1d_8_in_buf.sv
// Serial-to-parallel ping-pong frame buffer feeding the 8-point FFT core.
// Frames whose s_last does not land on the 8th sample are dropped and flagged.
module fft_1d_8_in_buf
  import fft_1d_8_in_buf_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N_PT   = FFT_N_PT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_W-1:0]      s_re,
  input  logic [DATA_W-1:0]      s_im,
  input  logic                   s_last,
  output logic                   f_valid,
  input  logic                   f_ready,
  output logic [N_PT*DATA_W-1:0] f_re,
  output logic [N_PT*DATA_W-1:0] f_im,
  output logic                   frame_err
);

  localparam int IDX_W = $clog2(N_PT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PT - 1);

  logic [1:0]             full;
  logic                   wr_bank;
  logic                   rd_bank;
  logic [IDX_W-1:0]       wr_idx;
  logic [N_PT*DATA_W-1:0] bank_re [2];
  logic [N_PT*DATA_W-1:0] bank_im [2];
  logic [N_PT*DATA_W-1:0] hold_re;
  logic [N_PT*DATA_W-1:0] hold_im;

  logic accept;
  logic consume;
  logic at_end;
  logic good_close;
  logic bad_close;

  assign s_ready    = ~full[wr_bank];
  assign f_valid    = full[rd_bank];
  assign accept     = s_valid & s_ready;
  assign consume    = f_valid & f_ready;
  assign at_end     = (wr_idx == LAST_IDX);
  assign good_close = accept & s_last & at_end;
  assign bad_close  = accept & (s_last ^ at_end);

  // A partial frame still lands in the bank; it is simply never marked full.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_1d_8_in_bank #(
      .DATA_W (DATA_W),
      .N_PT   (N_PT),
      .IDX_W  (IDX_W)
    ) u_bank (
      .clk   (clk),
      .we    (accept & (wr_bank == 1'(b))),
      .idx   (wr_idx),
      .wr_re (s_re),
      .wr_im (s_im),
      .rd_re (bank_re[b]),
      .rd_im (bank_im[b])
    );
  end

  // Between frames the output shows the last presented frame, or zero after reset.
  assign f_re = f_valid ? bank_re[rd_bank] : hold_re;
  assign f_im = f_valid ? bank_im[rd_bank] : hold_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      frame_err <= 1'b0;
      hold_re   <= '0;
      hold_im   <= '0;
    end else begin
      frame_err <= bad_close;
      if (accept) begin
        wr_idx <= (good_close | bad_close) ? '0 : wr_idx + 1'b1;
      end
      // Close and consume always target different banks, so both may fire.
      if (good_close) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (consume) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (f_valid) begin
        hold_re <= bank_re[rd_bank];
        hold_im <= bank_im[rd_bank];
      end
    end
  end

endmodule

// File: tb/tb_fft_1d_8_in_buf.sv
// Directed, scoreboard-checked bench for the FFT input ping-pong buffer.
// A small frame-assembly model pushes expected frames; a monitor pops on each consume.
module tb_fft_1d_8_in_buf;

  localparam int DW = 16;
  localparam int NP = 8;
  localparam int FW = NP * DW;

  typedef struct packed {
    logic [FW-1:0] re;
    logic [FW-1:0] im;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_re = '0;
  logic [DW-1:0] s_im = '0;
  logic          s_last = 1'b0;
  logic          f_valid;
  logic          f_ready = 1'b0;
  logic [FW-1:0] f_re;
  logic [FW-1:0] f_im;
  logic          frame_err;

  frame_t        exp_q[$];
  frame_t        mon_exp;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            err_seen = 0;
  int            err_exp = 0;
  int            pop_cnt = 0;
  int            stall_cnt = 0;
  int            valid_cnt = 0;
  int            m_idx = 0;
  logic [FW-1:0] m_re = '0;
  logic [FW-1:0] m_im = '0;
  logic [FW-1:0] single_re;
  frame_t        held;

  fft_1d_8_in_buf #(.DATA_W(DW), .N_PT(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_re      (s_re),
    .s_im      (s_im),
    .s_last    (s_last),
    .f_valid   (f_valid),
    .f_ready   (f_ready),
    .f_re      (f_re),
    .f_im      (f_im),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sampled on the falling edge; a consume here happens at the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) err_seen++;
      if (s_valid && !s_ready) stall_cnt++;
      if (f_valid) valid_cnt++;
      if (f_valid && f_ready) begin
        check_output("frame_expected", FW'(exp_q.size() > 0), FW'(1));
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          check_output("frame_re", f_re, mon_exp.re);
          check_output("frame_im", f_im, mon_exp.im);
          pop_cnt++;
        end
      end
    end
  end

  // One beat: hold it until accepted, then update the frame-assembly model.
  task automatic apply_stimulus(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_re    = re;
    s_im    = im;
    s_last  = last;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check_output("accept_in_time", FW'(ok), FW'(1));
    if (ok) begin
      m_re[m_idx*DW +: DW] = re;
      m_im[m_idx*DW +: DW] = im;
      if (last != (m_idx == NP - 1)) begin
        err_exp++;
        m_idx = 0;
      end else if (last) begin
        exp_q.push_back('{re: m_re, im: m_im});
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic send_frame(input int n, input logic [DW-1:0] re0, input logic [DW-1:0] im0,
                            input logic [DW-1:0] step, input int last_at);
    for (int k = 0; k < n; k++) begin
      apply_stimulus(re0 + DW'(k) * step, im0 - DW'(k) * step, k == last_at);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !f_valid) break;
      @(negedge clk);
    end
    check_output("drained", FW'(exp_q.size()), FW'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check_output("rst_f_valid", FW'(f_valid), FW'(0));
    check_output("rst_s_ready", FW'(s_ready), FW'(1));
    check_output("rst_frame_err", FW'(frame_err), FW'(0));
    check_output("rst_f_re", f_re, FW'(0));
    check_output("rst_f_im", f_im, FW'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame, re = im = k<<8
    $display("[TB] single frame");
    f_ready = 1'b1;
    for (int k = 0; k < NP; k++) begin
      single_re[k*DW +: DW] = DW'(k << 8);
      apply_stimulus(DW'(k << 8), DW'(k << 8), k == NP - 1);
    end
    check_output("single_valid_next_cycle", FW'(f_valid), FW'(1));
    check_output("single_re_direct", f_re, single_re);
    @(posedge clk);
    #1;
    check_output("single_consumed", FW'(f_valid), FW'(0));
    check_output("hold_after_consume", f_re, single_re);

    // Backpressure: two frames fill both banks, the third waits
    $display("[TB] backpressure");
    f_ready = 1'b0;
    send_frame(8, 16'h1000, 16'hF000, 16'h0011, 7);
    send_frame(8, 16'h2000, 16'hE000, 16'h0011, 7);
    held = exp_q[0];
    check_output("bp_s_ready_low", FW'(s_ready), FW'(0));
    check_output("bp_f_valid", FW'(f_valid), FW'(1));
    check_output("bp_hold_re", f_re, held.re);
    repeat (3) @(posedge clk);
    #1;
    check_output("bp_stable_re", f_re, held.re);
    check_output("bp_stable_im", f_im, held.im);
    check_output("bp_still_blocked", FW'(s_ready), FW'(0));
    fork
      send_frame(8, 16'h3000, 16'hD000, 16'h0011, 7);
      begin
        f_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("bp_ready_after_consume", FW'(s_ready), FW'(1));
      end
    join
    wait_drain();

    // Sustained throughput
    $display("[TB] sustained");
    stall_cnt = 0;
    pop_cnt   = 0;
    valid_cnt = 0;
    for (int f = 0; f < 8; f++) begin
      send_frame(8, DW'(16'h8000 + f * 16'h0100), DW'(16'h7F00 - f * 16'h0100), 16'h0003, 7);
    end
    wait_drain();
    check_output("sus_no_stall", FW'(stall_cnt), FW'(0));
    check_output("sus_frames", FW'(pop_cnt), FW'(8));
    check_output("sus_valid_cycles", FW'(valid_cnt), FW'(8));

    // Early s_last on the 5th sample
    $display("[TB] misaligned");
    send_frame(5, 16'h4000, 16'hC000, 16'h0001, 4);
    check_output("mis_err_pulse", FW'(frame_err), FW'(1));
    check_output("mis_no_valid", FW'(f_valid), FW'(0));
    @(posedge clk);
    #1;
    check_output("mis_err_one_cycle", FW'(frame_err), FW'(0));
    check_output("mis_err_count", FW'(err_seen), FW'(err_exp));
    send_frame(8, 16'h4100, 16'hBF00, 16'h0005, 7);
    wait_drain();

    // Missing s_last on the 8th sample
    $display("[TB] missing last");
    send_frame(8, 16'h5000, 16'hB000, 16'h0002, -1);
    check_output("miss_err_pulse", FW'(frame_err), FW'(1));
    check_output("miss_no_valid", FW'(f_valid), FW'(0));
    send_frame(8, 16'h5100, 16'hAF00, 16'h0007, 7);
    wait_drain();
    check_output("miss_err_count", FW'(err_seen), FW'(err_exp));

    // Asynchronous reset mid-frame
    $display("[TB] async reset");
    send_frame(3, 16'h6000, 16'hA000, 16'h0001, -1);
    #3;
    rst_n = 1'b0;
    #1;
    m_idx = 0;
    check_output("arst_f_valid", FW'(f_valid), FW'(0));
    check_output("arst_frame_err", FW'(frame_err), FW'(0));
    check_output("arst_f_re", f_re, FW'(0));
    check_output("arst_f_im", f_im, FW'(0));
    check_output("arst_s_ready", FW'(s_ready), FW'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(8, 16'h6100, 16'h9F00, 16'h0009, 7);
    wait_drain();
    check_output("final_err_count", FW'(err_seen), FW'(err_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
